// File: rtl/bcd_disp_counter.sv
// rtl/bcd_disp_counter.sv - four-digit BCD up/down counter with blank flags and scan strobe
module bcd_disp_counter #(
  parameter int TICK_DIV = 50_000_000,
  parameter int SCAN_DIV = 50_000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        En,
  input  logic        Up,
  input  logic        Clr,
  input  logic        Load,
  input  logic [15:0] Load_val,
  output logic [15:0] Digits,
  output logic [3:0]  Blank,
  output logic        Wrap,
  output logic        Scan_tick
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

  logic [PW-1:0] pre;
  logic [SW-1:0] scan_cnt;
  logic [15:0]   stepped;
  logic [15:0]   load_sat;
  logic          carry;
  logic [3:0]    d;

  // Ripple carry/borrow through the digits; a carry out of digit 3 is the wrap.
  always_comb begin
    stepped = Digits;
    carry   = 1'b1;
    d       = 4'd0;
    for (int i = 0; i < 4; i++) begin
      d = Digits[4*i +: 4];
      if (carry) begin
        if (Up) begin
          if (d >= 4'd9) begin
            stepped[4*i +: 4] = 4'd0;
          end else begin
            stepped[4*i +: 4] = d + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            stepped[4*i +: 4] = 4'd9;
          end else begin
            stepped[4*i +: 4] = d - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    load_sat = Load_val;
    for (int i = 0; i < 4; i++) begin
      if (Load_val[4*i +: 4] > 4'd9) load_sat[4*i +: 4] = 4'd9;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Digits <= 16'h0000;
      pre    <= '0;
      Wrap   <= 1'b0;
    end else begin
      Wrap <= 1'b0;
      if (Clr) begin
        Digits <= 16'h0000;
        pre    <= '0;
      end else if (Load) begin
        Digits <= load_sat;
        pre    <= '0;
      end else if (En) begin
        if (pre == PRE_MAX) begin
          pre    <= '0;
          Digits <= stepped;
          Wrap   <= carry;
        end else begin
          pre <= pre + PW'(1);
        end
      end
    end
  end

  // Free-running scan divider, deliberately unaffected by En/Clr/Load.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      scan_cnt  <= '0;
      Scan_tick <= 1'b0;
    end else if (scan_cnt == SCAN_MAX) begin
      scan_cnt  <= '0;
      Scan_tick <= 1'b1;
    end else begin
      scan_cnt  <= scan_cnt + SW'(1);
      Scan_tick <= 1'b0;
    end
  end

  assign Blank[3] = (Digits[15:12] == 4'd0);
  assign Blank[2] = Blank[3] & (Digits[11:8] == 4'd0);
  assign Blank[1] = Blank[2] & (Digits[7:4] == 4'd0);
  assign Blank[0] = 1'b0;

endmodule
